// File: rtl/ysyx_22040759_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Stalls and flushes come from four sources, highest priority first:
//   - pipe_freeze while the AXI data port is outstanding (mem_req & ~mem_ready)
//   - redirect flush when EX resolves a taken branch/jump
//   - load-use bubbles (LOAD_LAT per hazard; x0 never stalls)
//   - an IF bubble while the AXI instruction port is not ready
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   if_id_rs*_i, if_id_rs*_used_i  source registers of the ID instruction
//   id_ex_rd_i, id_ex_memread_i    destination / load flag of the EX instruction
//   br_taken_i                     redirect from EX
//   if_req_i, if_ready_i           AXI instruction port handshake
//   mem_req_i, mem_ready_i         AXI data port handshake
//   cnt_clr_i                      synchronous clear of stall_cycles_o
//   pc_stall_o .. pipe_freeze_o    combinational pipeline controls
//   stall_cycles_o                 saturating count of stalled cycles
//   mem_timeout_o                  sticky: a freeze lasted MAX_WAIT cycles
module ysyx_22040759_hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned MAX_WAIT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] if_id_rs1_i,
    input  logic [REG_AW-1:0] if_id_rs2_i,
    input  logic              if_id_rs1_used_i,
    input  logic              if_id_rs2_used_i,
    input  logic [REG_AW-1:0] id_ex_rd_i,
    input  logic              id_ex_memread_i,
    input  logic              br_taken_i,
    input  logic              if_req_i,
    input  logic              if_ready_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    input  logic              cnt_clr_i,
    output logic              pc_stall_o,
    output logic              if_id_stall_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              id_ex_flush_o,
    output logic              pipe_freeze_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic              mem_timeout_o
);

    localparam logic StRun     = 1'b0;
    localparam logic StLuStall = 1'b1;

    localparam int unsigned WaitW = $clog2(MAX_WAIT);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);
    localparam logic [2:0] LuInit = 3'(LOAD_LAT - 1);

    logic             state_q, state_d;
    logic [2:0]       lu_cnt_q, lu_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic lu_hit;
    logic freeze;
    logic if_wait;

    assign lu_hit = id_ex_memread_i && (id_ex_rd_i != '0) &&
                    ((if_id_rs1_used_i && (id_ex_rd_i == if_id_rs1_i)) ||
                     (if_id_rs2_used_i && (id_ex_rd_i == if_id_rs2_i)));
    assign freeze  = mem_req_i && !mem_ready_i;
    assign if_wait = if_req_i && !if_ready_i;

    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_bubble_o = 1'b0;
        id_ex_flush_o  = 1'b0;
        pipe_freeze_o  = 1'b0;
        state_d        = state_q;
        lu_cnt_d       = lu_cnt_q;

        if (!rst_ni) begin
            // Outputs stay quiet while reset is held.
        end else if (freeze) begin
            // Everything holds; a pending br_taken is seen once EX unfreezes.
            pipe_freeze_o = 1'b1;
            pc_stall_o    = 1'b1;
        end else if (br_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            state_d       = StRun;
            lu_cnt_d      = '0;
        end else if ((state_q == StRun && lu_hit) || state_q == StLuStall) begin
            pc_stall_o     = 1'b1;
            if_id_stall_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
            if (state_q == StRun) begin
                if (LOAD_LAT > 1) begin
                    state_d  = StLuStall;
                    lu_cnt_d = LuInit;
                end
            end else if (lu_cnt_q == 3'd1) begin
                // Last bubble of this hazard.
                state_d  = StRun;
                lu_cnt_d = '0;
            end else begin
                lu_cnt_d = lu_cnt_q - 3'd1;
            end
        end else if (if_wait) begin
            pc_stall_o    = 1'b1;
            if_id_flush_o = 1'b1;
        end
    end

    always_comb begin
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        if (freeze) begin
            wait_cnt_d = (wait_cnt_q == WaitLast) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_q == WaitLast) begin
                mem_timeout_d = 1'b1;
            end
        end

        stall_cycles_d = stall_cycles_q;
        if (cnt_clr_i) begin
            stall_cycles_d = '0;
        end else if ((pc_stall_o || pipe_freeze_o) && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StRun;
            lu_cnt_q       <= '0;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            lu_cnt_q       <= lu_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign mem_timeout_o  = mem_timeout_q;

endmodule

// File: tb/tb_ysyx_22040759_hazard_ctrl.sv
// Randomized bench for ysyx_22040759_hazard_ctrl. Two instances share one input stream:
// instance 0 with LOAD_LAT=3, instance 1 with LOAD_LAT=1, small counters to reach saturation.
// The reference tracks "bubbles still owed", the length of the current freeze run and a
// clamped stall count.
module tb_ysyx_22040759_hazard_ctrl;

    localparam int unsigned RegAw = 5;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [RegAw-1:0] rs1, rs2, rd;
    logic             rs1_used, rs2_used, memread, br_taken;
    logic             if_req, if_ready, mem_req, mem_ready, cnt_clr;

    always #5 clk_i = ~clk_i;

    logic [5:0] ctrl_w [2];
    logic [5:0] sc0_w;
    logic [4:0] sc1_w;
    logic       to_w   [2];

    logic a_pc, a_ifs, a_iff, a_bub, a_exf, a_frz;
    logic b_pc, b_ifs, b_iff, b_bub, b_exf, b_frz;

    ysyx_22040759_hazard_ctrl #(
        .REG_AW(RegAw), .LOAD_LAT(3), .CNT_W(6), .MAX_WAIT(8)
    ) u_dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2),
        .if_id_rs1_used_i(rs1_used), .if_id_rs2_used_i(rs2_used),
        .id_ex_rd_i(rd), .id_ex_memread_i(memread), .br_taken_i(br_taken),
        .if_req_i(if_req), .if_ready_i(if_ready),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready), .cnt_clr_i(cnt_clr),
        .pc_stall_o(a_pc), .if_id_stall_o(a_ifs), .if_id_flush_o(a_iff),
        .id_ex_bubble_o(a_bub), .id_ex_flush_o(a_exf), .pipe_freeze_o(a_frz),
        .stall_cycles_o(sc0_w), .mem_timeout_o(to_w[0])
    );

    ysyx_22040759_hazard_ctrl #(
        .REG_AW(RegAw), .LOAD_LAT(1), .CNT_W(5), .MAX_WAIT(5)
    ) u_dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .if_id_rs1_i(rs1), .if_id_rs2_i(rs2),
        .if_id_rs1_used_i(rs1_used), .if_id_rs2_used_i(rs2_used),
        .id_ex_rd_i(rd), .id_ex_memread_i(memread), .br_taken_i(br_taken),
        .if_req_i(if_req), .if_ready_i(if_ready),
        .mem_req_i(mem_req), .mem_ready_i(mem_ready), .cnt_clr_i(cnt_clr),
        .pc_stall_o(b_pc), .if_id_stall_o(b_ifs), .if_id_flush_o(b_iff),
        .id_ex_bubble_o(b_bub), .id_ex_flush_o(b_exf), .pipe_freeze_o(b_frz),
        .stall_cycles_o(sc1_w), .mem_timeout_o(to_w[1])
    );

    // Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_flush, freeze}
    assign ctrl_w[0] = {a_pc, a_ifs, a_iff, a_bub, a_exf, a_frz};
    assign ctrl_w[1] = {b_pc, b_ifs, b_iff, b_bub, b_exf, b_frz};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference model state per instance.
    int lat  [2] = '{3, 1};
    int maxw [2] = '{8, 5};
    int cmax [2] = '{63, 31};
    int owed [2];
    int frun [2];
    int stl  [2];
    int tout [2];

    function automatic bit ref_hit();
        return memread && rd != 0 &&
               ((rs1_used && rd == rs1) || (rs2_used && rd == rs2));
    endfunction

    function automatic logic [5:0] ref_ctrl(input int k);
        if (mem_req && !mem_ready) return 6'b100001;
        if (br_taken)              return 6'b001010;
        if (owed[k] > 0 || ref_hit()) return 6'b110100;
        if (if_req && !if_ready)   return 6'b101000;
        return 6'b000000;
    endfunction

    task automatic model_reset(input int k);
        owed[k] = 0;
        frun[k] = 0;
        stl[k]  = 0;
        tout[k] = 0;
    endtask

    task automatic model_step(input int k);
        logic [5:0] c;
        bit fz;
        c  = ref_ctrl(k);
        fz = mem_req && !mem_ready;
        if (!fz) begin
            if (br_taken)         owed[k] = 0;
            else if (owed[k] > 0) owed[k] = owed[k] - 1;
            else if (ref_hit())   owed[k] = lat[k] - 1;
        end
        if (cnt_clr)              stl[k] = 0;
        else if (c[5] || c[0])    stl[k] = (stl[k] + 1 > cmax[k]) ? cmax[k] : stl[k] + 1;
        if (fz && frun[k] >= maxw[k] - 1) tout[k] = 1;
        frun[k] = fz ? frun[k] + 1 : 0;
    endtask

    // Inputs are set just after a rising edge; checks happen mid-cycle.
    task automatic run_cycle();
        int sc [2];
        #2;
        sc[0] = int'(sc0_w);
        sc[1] = int'(sc1_w);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("dut%0d.ctrl", k), int'(ctrl_w[k]),
                     rst_ni ? int'(ref_ctrl(k)) : 0);
            check_eq($sformatf("dut%0d.stall_cycles", k), sc[k], rst_ni ? stl[k] : 0);
            check_eq($sformatf("dut%0d.mem_timeout", k), int'(to_w[k]), rst_ni ? tout[k] : 0);
        end
        @(posedge clk_i);
        for (int k = 0; k < 2; k++) begin
            if (rst_ni) model_step(k);
            else        model_reset(k);
        end
        #1;
    endtask

    task automatic drive_idle();
        rs1 = '0; rs2 = '0; rd = '0;
        rs1_used = 1'b0; rs2_used = 1'b0; memread = 1'b0; br_taken = 1'b0;
        if_req = 1'b0; if_ready = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
    endtask

    int burst = 0;

    initial begin
        drive_idle();
        model_reset(0);
        model_reset(1);

        // Reset held with a live hazard on the inputs: all outputs must stay 0.
        rst_ni = 1'b0;
        memread = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1; if_req = 1'b1;
        #1;
        run_cycle();
        run_cycle();
        rst_ni = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            rs1      = 5'($urandom_range(0, 3));
            rs2      = 5'($urandom_range(0, 3));
            rd       = 5'($urandom_range(0, 3));
            rs1_used = 1'($urandom_range(0, 1));
            rs2_used = 1'($urandom_range(0, 1));
            memread  = 1'($urandom_range(0, 1));
            br_taken = ($urandom_range(0, 7) == 0);
            if_req   = 1'($urandom_range(0, 1));
            if_ready = 1'($urandom_range(0, 1));
            cnt_clr  = ($urandom_range(0, 63) == 0);
            if (burst > 0) begin
                mem_req = 1'b1; mem_ready = 1'b0; burst--;
            end else begin
                if ($urandom_range(0, 15) == 0) burst = $urandom_range(1, 10);
                mem_req   = ($urandom_range(0, 3) == 0);
                mem_ready = 1'($urandom_range(0, 1));
            end
            rst_ni = ($urandom_range(0, 127) != 0);
            run_cycle();
            rst_ni = 1'b1;
        end

        // Directed: 8-cycle freeze, sticky timeout, counter clear, async reset.
        drive_idle();
        rst_ni = 1'b0;
        run_cycle();
        rst_ni = 1'b1;
        mem_req = 1'b1;
        for (int i = 0; i < 8; i++) run_cycle();
        mem_req = 1'b0;
        run_cycle();
        run_cycle();
        check_eq("dut0.timeout_sticky", int'(to_w[0]), 1);
        check_eq("dut0.freeze_count", int'(sc0_w), 8);
        cnt_clr = 1'b1;
        run_cycle();
        cnt_clr = 1'b0;
        run_cycle();
        rst_ni = 1'b0;
        #1;
        check_eq("dut0.timeout_async_clr", int'(to_w[0]), 0);
        check_eq("dut1.timeout_async_clr", int'(to_w[1]), 0);
        run_cycle();
        rst_ni = 1'b1;
        run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
